// File: rtl/serdes_pkg.sv
// Shared definitions for the lane serializer: lane count and
// output sequencing states.
package serdes_pkg;

    localparam int LANES      = 2;
    localparam int LANE_IDX_W = 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LANE0 = 2'd1,
        LANE1 = 2'd2
    } state_t;

endpackage

// File: rtl/lane_serializer_2to1.sv
// Turns one 2-lane vector per handshake into two single-lane beats,
// lane 0 first, with back-to-back vectors and no bubble.
module lane_serializer_2to1
    import serdes_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             CE,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             valid_data_in,
    output logic             ready_data_in,
    output logic [WIDTH-1:0] O,
    output logic             last_out,
    output logic             valid_data_out,
    input  logic             ready_data_out
);

    state_t                   state;
    state_t                   state_n;
    logic [LANES*WIDTH-1:0]   vec;
    logic                     capture;
    logic                     in_fire;
    logic                     out_fire;

    assign valid_data_out = RESETN && (state != EMPTY);
    assign last_out       = RESETN && (state == LANE1);

    // Accept a new vector only when the last beat of the held one leaves now.
    assign ready_data_in = RESETN && CE &&
                           ((state == EMPTY) ||
                            ((state == LANE1) && ready_data_out));

    assign in_fire  = CE && valid_data_in && ready_data_in;
    assign out_fire = CE && valid_data_out && ready_data_out;

    always_comb begin
        O = '0;
        unique case (state)
            LANE0:   O = vec[WIDTH-1:0];
            LANE1:   O = vec[2*WIDTH-1:WIDTH];
            default: O = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        capture = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    capture = 1'b1;
                    state_n = LANE0;
                end
            end
            LANE0: begin
                if (out_fire) state_n = LANE1;
            end
            LANE1: begin
                if (out_fire) begin
                    if (in_fire) begin
                        capture = 1'b1;
                        state_n = LANE0;
                    end else begin
                        state_n = EMPTY;
                    end
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= EMPTY;
            vec   <= '0;
        end else if (CE) begin
            state <= state_n;
            if (capture) vec <= {I1, I0};
        end
    end

endmodule

// File: tb/tb_lane_serializer_2to1.sv
// Directed bench for lane_serializer_2to1: a beat-queue model checked
// every cycle plus literal expectations for each scenario.
module tb_lane_serializer_2to1;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             RESETN = 1'b0;
    logic             CE = 1'b1;
    logic [WIDTH-1:0] I0 = '0;
    logic [WIDTH-1:0] I1 = '0;
    logic             valid_data_in = 1'b0;
    logic             ready_data_in;
    logic [WIDTH-1:0] O;
    logic             last_out;
    logic             valid_data_out;
    logic             ready_data_out = 1'b1;

    lane_serializer_2to1 #(.WIDTH(WIDTH)) dut (
        .CLK           (CLK),
        .RESETN        (RESETN),
        .CE            (CE),
        .I0            (I0),
        .I1            (I1),
        .valid_data_in (valid_data_in),
        .ready_data_in (ready_data_in),
        .O             (O),
        .last_out      (last_out),
        .valid_data_out(valid_data_out),
        .ready_data_out(ready_data_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WIDTH-1:0] data;
        bit               last;
    } beat_t;

    beat_t            mq[$];
    logic [WIDTH-1:0] got_d[$];
    int               got_c[$];
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return RESETN && CE &&
               (mq.size() == 0 || (mq.size() == 1 && ready_data_out));
    endfunction

    // Model: the block is a queue of pending beats, at most one vector deep.
    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            mq.delete();
        end else begin
            bit inf;
            bit outf;
            cyc++;
            inf  = CE && valid_data_in && model_ready();
            outf = CE && (mq.size() > 0) && ready_data_out;
            if (outf) void'(mq.pop_front());
            if (inf) begin
                mq.push_back('{data: I0, last: 1'b0});
                mq.push_back('{data: I1, last: 1'b1});
            end
        end
    end

    always @(negedge CLK) begin
        bit               ev;
        bit               el;
        logic [WIDTH-1:0] eo;
        ev = RESETN && (mq.size() > 0);
        el = ev && mq[0].last;
        eo = ev ? mq[0].data : '0;
        chk("model_valid", valid_data_out, ev);
        chk("model_last", last_out, el);
        chk("model_O", O, eo);
        chk("model_ready_in", ready_data_in, model_ready());
        if (CE && valid_data_out && ready_data_out) begin
            got_d.push_back(O);
            got_c.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!ready_data_in && n < 10) begin
            tick();
            n++;
        end
        if (!ready_data_in) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: ready_data_in timeout, got 0 expected 1", nm);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        I0 = a;
        I1 = b;
        valid_data_in = 1'b1;
        wait_ready("send");
        tick();
        valid_data_in = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_s[8];

        // Reset held with valid asserted
        valid_data_in = 1'b1;
        I0 = 8'h5A;
        I1 = 8'hA5;
        repeat (3) begin
            tick();
            chk("rst_valid", valid_data_out, 0);
            chk("rst_ready", ready_data_in, 0);
            chk("rst_O", O, 0);
        end
        valid_data_in = 1'b0;
        RESETN = 1'b1;
        #1;
        chk("rel_ready", ready_data_in, 1);
        tick();

        // Single vector
        send(8'h02, 8'h03);
        chk("sv_O0", O, 8'h02);
        chk("sv_last0", last_out, 0);
        tick();
        chk("sv_O1", O, 8'h03);
        chk("sv_last1", last_out, 1);
        tick();
        chk("sv_empty", valid_data_out, 0);
        tick();

        // Streaming four vectors
        got_d.delete();
        got_c.delete();
        exp_s = '{8'h10, 8'h11, 8'h20, 8'h21,
                  8'h30, 8'h31, 8'h40, 8'h41};
        for (int k = 0; k < 4; k++) begin
            I0 = 8'((k + 1) * 16);
            I1 = 8'((k + 1) * 16 + 1);
            valid_data_in = 1'b1;
            wait_ready("stream");
            tick();
        end
        valid_data_in = 1'b0;
        repeat (3) tick();
        chk("st_count", got_d.size(), 8);
        for (int i = 0; i < 8 && i < got_d.size(); i++) begin
            chk("st_data", got_d[i], exp_s[i]);
            chk("st_gap", got_c[i] - got_c[0], i);
        end

        // Backpressure in LANE1, then back-to-back accept
        send(8'hAA, 8'hBB);
        tick();
        ready_data_out = 1'b0;
        I0 = 8'h12;
        I1 = 8'h34;
        valid_data_in = 1'b1;
        repeat (5) begin
            tick();
            chk("bp_O", O, 8'hBB);
            chk("bp_last", last_out, 1);
            chk("bp_ready_in", ready_data_in, 0);
        end
        ready_data_out = 1'b1;
        #1;
        chk("bp_release_ready", ready_data_in, 1);
        tick();
        valid_data_in = 1'b0;
        chk("bp_next_O", O, 8'h12);
        chk("bp_next_last", last_out, 0);
        repeat (3) tick();

        // CE low mid-vector
        send(8'hFF, 8'h00);
        CE = 1'b0;
        I0 = 8'h55;
        I1 = 8'h66;
        valid_data_in = 1'b1;
        repeat (3) begin
            tick();
            chk("ce_O", O, 8'hFF);
            chk("ce_valid", valid_data_out, 1);
            chk("ce_last", last_out, 0);
            chk("ce_ready_in", ready_data_in, 0);
        end
        valid_data_in = 1'b0;
        CE = 1'b1;
        tick();
        chk("ce_resume_O", O, 8'h00);
        chk("ce_resume_last", last_out, 1);
        tick();
        chk("ce_done", valid_data_out, 0);
        tick();

        // Reset while presenting lane 1
        send(8'h77, 8'h88);
        tick();
        chk("mr_in_lane1", last_out, 1);
        RESETN = 1'b0;
        #1;
        chk("mr_valid", valid_data_out, 0);
        chk("mr_O", O, 0);
        tick();
        RESETN = 1'b1;
        tick();
        send(8'h01, 8'h02);
        chk("mr_next_O", O, 8'h01);
        chk("mr_next_last", last_out, 0);
        tick();
        chk("mr_next_O1", O, 8'h02);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
